rx_data_sr: RTL and testbench
=============================

RX_DATA_SR -- requirements
Module: rx_data_sr

Interface
REQ-001: Parameter NUM_BYTES, default 8, number of bytes per assembled word; word width W = 8*NUM_BYTES (64 at default).
REQ-002: clk  input  1  system clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: sda_in  input  1  synchronized serial data line.
REQ-005: rising_edge_found  input  1  one-clk pulse marking an SCL rising edge (sample point).
REQ-006: rx_enable  input  1  gates sampling; low during ACK slots and when not addressed.
REQ-007: clear_pos  input  1  one-clk pulse on START/STOP detection; aborts any partial word.
REQ-008: data_read  input  1  consumer acknowledge of rx_data.
REQ-009: rx_data  output  W  last completed word, first received bit in MSB.
REQ-010: rx_full  output  1  rx_data holds an unread word.
REQ-011: byte_received  output  1  one-clk pulse after each completed byte.
REQ-012: overrun  output  1  sticky flag: a word completed while rx_full was set.
REQ-013: busy  output  1  partial word in progress (bit or byte count nonzero).

Function
REQ-014: Sample event = rising_edge_found & rx_enable & ~clear_pos; only sample events change shift state.
REQ-015: On sample event, shift register (W bits) shifts left by one, sda_in entering bit 0 (MSB-first reception).
REQ-016: 3-bit bit counter increments per sample event; wraps 7->0 on 8th bit of a byte.
REQ-017: On bit-counter wrap, byte counter increments; byte_received asserts for exactly the next clk cycle.
REQ-018: Byte counter wraps NUM_BYTES-1 -> 0 on the final bit of a word (word completion).
REQ-019: On word completion with rx_full=0, or with data_read=1 in the same cycle, rx_data loads the completed word (including the bit sampled that cycle) and rx_full=1 next cycle.
REQ-020: On word completion with rx_full=1 and data_read=0: rx_data unchanged, rx_full stays 1, overrun=1 next cycle; new word discarded.
REQ-021: data_read with rx_full=1 and no simultaneous word completion clears rx_full and overrun next cycle.
REQ-022: data_read with rx_full=0 has no effect.
REQ-023: clear_pos zeroes shift register, bit counter, byte counter next cycle; rx_data, rx_full, overrun unaffected; clear_pos wins over a simultaneous rising_edge_found.
REQ-024: rising_edge_found with rx_enable=0 changes nothing; counters hold position (ACK slot does not count).
REQ-025: busy = (bit counter != 0) | (byte counter != 0), registered-state derived, no combinational path from inputs.
REQ-026: Latency: rx_data/rx_full valid 1 clk after the sampling edge of the last bit; byte_received 1 clk after 8th bit sample.

Reset
REQ-027: While rst=1 at a clk edge: shift register, counters, rx_data = 0; rx_full, overrun, byte_received, busy = 0; rst overrides all other inputs.
REQ-028: Reset mid-word discards partial data; first sample after reset is bit 7 of byte 0.

Verification
REQ-029: Reset, then 64 samples (rx_enable=1) of 0xA5C3_0F1E_8877_6655 MSB-first -> rx_data=0xA5C30F1E88776655, rx_full=1 one clk after last sample, 8 byte_received pulses.
REQ-030: Same word with rx_enable=0 across one rising_edge_found after each byte (ACK slot) -> identical rx_data; ACK edges not counted.
REQ-031: 20 bits sent, clear_pos pulse, then full word 0x0123456789ABCDEF -> rx_data=0x0123456789ABCDEF, busy=0 after completion.
REQ-032: Word A received, no data_read, word B received -> rx_data=A, overrun=1; data_read -> rx_full=0, overrun=0 next clk.
REQ-033: data_read asserted in the same cycle as word B's last sample with rx_full=1 -> rx_data=B, rx_full=1, overrun=0.
REQ-034: rst asserted after 35 bits -> all outputs 0 next clk; following 64-bit word 0xFFFF0000FFFF0000 received correctly.

Source files
------------

// File: rtl/rx_data_sr.sv
// Serial-to-parallel receive register: assembles MSB-first bits into NUM_BYTES-byte words,
// with a one-word holding register, full/overrun handshake and START/STOP abort.
module rx_data_sr #(
   parameter int NUM_BYTES = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   sda_in,
   input  logic                   rising_edge_found,
   input  logic                   rx_enable,
   input  logic                   clear_pos,
   input  logic                   data_read,
   output logic [8*NUM_BYTES-1:0] rx_data,
   output logic                   rx_full,
   output logic                   byte_received,
   output logic                   overrun,
   output logic                   busy
);

   localparam int W  = 8 * NUM_BYTES;
   localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);

   logic [W-1:0]  shift_q, shift_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [BW-1:0] byte_cnt_q, byte_cnt_d;
   logic [W-1:0]  rx_data_q, rx_data_d;
   logic          rx_full_q, rx_full_d;
   logic          overrun_q, overrun_d;
   logic          byte_received_q, byte_received_d;

   logic          sample;
   logic          byte_done;
   logic          word_done;
   logic [W-1:0]  word_in;

   // An ACK slot (rx_enable low) and an abort cycle must not move the counters.
   assign sample    = rising_edge_found & rx_enable & ~clear_pos;
   assign byte_done = sample & (bit_cnt_q == 3'd7);
   assign word_done = byte_done & (byte_cnt_q == LAST_BYTE);
   assign word_in   = {shift_q[W-2:0], sda_in};

   // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      shift_d         = shift_q;
      bit_cnt_d       = bit_cnt_q;
      byte_cnt_d      = byte_cnt_q;
      rx_data_d       = rx_data_q;
      rx_full_d       = rx_full_q;
      overrun_d       = overrun_q;
      byte_received_d = byte_done;

      if (clear_pos) begin
         shift_d    = '0;
         bit_cnt_d  = '0;
         byte_cnt_d = '0;
      end else if (sample) begin
         shift_d   = word_in;
         bit_cnt_d = bit_cnt_q + 3'd1;
         if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = (byte_cnt_q == LAST_BYTE) ? '0 : byte_cnt_q + BW'(1);
         end
      end

      // A read in the completion cycle frees the holding register just in time for the new word.
      if (word_done) begin
         if (!rx_full_q || data_read) begin
            rx_data_d = word_in;
            rx_full_d = 1'b1;
            overrun_d = 1'b0;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (data_read && rx_full_q) begin
         rx_full_d = 1'b0;
         overrun_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q         <= '0;
         bit_cnt_q       <= '0;
         byte_cnt_q      <= '0;
         rx_data_q       <= '0;
         rx_full_q       <= 1'b0;
         overrun_q       <= 1'b0;
         byte_received_q <= 1'b0;
      end else begin
         shift_q         <= shift_d;
         bit_cnt_q       <= bit_cnt_d;
         byte_cnt_q      <= byte_cnt_d;
         rx_data_q       <= rx_data_d;
         rx_full_q       <= rx_full_d;
         overrun_q       <= overrun_d;
         byte_received_q <= byte_received_d;
      end
   end

   assign rx_data       = rx_data_q;
   assign rx_full       = rx_full_q;
   assign overrun       = overrun_q;
   assign byte_received = byte_received_q;
   assign busy          = (bit_cnt_q != 3'd0) | (byte_cnt_q != '0);

endmodule

// File: tb/tb_rx_data_sr.sv
// Directed bench for rx_data_sr: words shifted in MSB-first, expected words queued on send
// and popped when the holding register is expected to load.
module tb_rx_data_sr;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sda_in = 1'b0;
   logic        rising_edge_found = 1'b0;
   logic        rx_enable = 1'b0;
   logic        clear_pos = 1'b0;
   logic        data_read = 1'b0;
   logic [63:0] rx_data;
   logic        rx_full;
   logic        byte_received;
   logic        overrun;
   logic        busy;

   int          checks = 0;
   int          failures = 0;
   int          br_count = 0;
   int          br_base = 0;
   logic [63:0] exp_q[$];
   logic [63:0] exp_word;

   rx_data_sr #(.NUM_BYTES(8)) dut (
      .clk               (clk),
      .rst               (rst),
      .sda_in            (sda_in),
      .rising_edge_found (rising_edge_found),
      .rx_enable         (rx_enable),
      .clear_pos         (clear_pos),
      .data_read         (data_read),
      .rx_data           (rx_data),
      .rx_full           (rx_full),
      .byte_received     (byte_received),
      .overrun           (overrun),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (byte_received === 1'b1) br_count <= br_count + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_pop(input string tag);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s: observed=%h expected=<empty scoreboard>", tag, rx_data);
      end else begin
         exp_word = exp_q.pop_front();
         check(tag, rx_data, exp_word);
      end
   endtask

   // Sends the top n bits of w MSB-first; returns 1 time unit after the last sampling edge.
   task automatic send_bits(input logic [63:0] w, input int n, input bit ack, input bit rd_last);
      for (int i = 0; i < n; i++) begin
         sda_in            = w[63-i];
         rising_edge_found = 1'b1;
         rx_enable         = 1'b1;
         data_read         = rd_last && (i == n - 1);
         tick();
         rising_edge_found = 1'b0;
         data_read         = 1'b0;
         if (i != n - 1) begin
            if (ack && ((i + 1) % 8 == 0)) begin
               rx_enable         = 1'b0;
               sda_in            = 1'b0;
               rising_edge_found = 1'b1;
               tick();
               rising_edge_found = 1'b0;
               rx_enable         = 1'b1;
            end
            tick();
         end
      end
   endtask

   task automatic pulse_read();
      data_read = 1'b1;
      tick();
      data_read = 1'b0;
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check("rst_rx_data", rx_data, 64'h0);
      check("rst_rx_full", 64'(rx_full), 64'h0);
      check("rst_overrun", 64'(overrun), 64'h0);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_byte_received", 64'(byte_received), 64'h0);

      // Plain 64-bit word
      br_base = br_count;
      exp_q.push_back(64'hA5C3_0F1E_8877_6655);
      send_bits(64'hA5C3_0F1E_8877_6655, 64, 1'b0, 1'b0);
      check("w1_rx_full", 64'(rx_full), 64'h1);
      check_pop("w1_rx_data");
      check("w1_byte_received_latency", 64'(byte_received), 64'h1);
      check("w1_busy", 64'(busy), 64'h0);
      tick();
      check("w1_byte_received_width", 64'(byte_received), 64'h0);
      check("w1_byte_count", 64'(br_count - br_base), 64'd8);
      pulse_read();
      check("w1_read_clears_full", 64'(rx_full), 64'h0);
      check("w1_read_keeps_data", rx_data, 64'hA5C3_0F1E_8877_6655);

      // Unread-empty read has no effect
      pulse_read();
      check("idle_read_full", 64'(rx_full), 64'h0);
      check("idle_read_data", rx_data, 64'hA5C3_0F1E_8877_6655);

      // Same word with ACK edges (rx_enable low) between bytes
      br_base = br_count;
      send_bits(64'hA5C3_0F1E_8877_6655, 8, 1'b1, 1'b0);
      tick();
      rx_enable         = 1'b0;
      rising_edge_found = 1'b1;
      tick();
      rising_edge_found = 1'b0;
      rx_enable         = 1'b1;
      check("ack_busy_mid", 64'(busy), 64'h1);
      exp_q.push_back(64'hA5C3_0F1E_8877_6655);
      send_bits(64'h0000_0000_0000_0000 | (64'hA5C3_0F1E_8877_6655 << 8), 56, 1'b1, 1'b0);
      check("ack_rx_full", 64'(rx_full), 64'h1);
      check_pop("ack_rx_data");
      tick();
      check("ack_byte_count", 64'(br_count - br_base), 64'd8);
      check("ack_busy_end", 64'(busy), 64'h0);
      pulse_read();

      // 20 partial bits, abort with clear_pos (colliding with an edge), then a full word
      send_bits(64'hFFFF_F000_0000_0000, 20, 1'b0, 1'b0);
      tick();
      check("clr_busy_before", 64'(busy), 64'h1);
      clear_pos         = 1'b1;
      rising_edge_found = 1'b1;
      sda_in            = 1'b1;
      tick();
      clear_pos         = 1'b0;
      rising_edge_found = 1'b0;
      check("clr_busy_after", 64'(busy), 64'h0);
      check("clr_keeps_rx_data", rx_data, 64'hA5C3_0F1E_8877_6655);
      check("clr_keeps_rx_full", 64'(rx_full), 64'h0);
      exp_q.push_back(64'h0123_4567_89AB_CDEF);
      send_bits(64'h0123_4567_89AB_CDEF, 64, 1'b0, 1'b0);
      check("clr_word_full", 64'(rx_full), 64'h1);
      check_pop("clr_word_data");
      check("clr_word_busy", 64'(busy), 64'h0);

      // Overrun: second word arrives while first is unread
      tick();
      send_bits(64'h1122_3344_5566_7788, 64, 1'b0, 1'b0);
      check("ovr_rx_data_kept", rx_data, 64'h0123_4567_89AB_CDEF);
      check("ovr_flag", 64'(overrun), 64'h1);
      check("ovr_rx_full", 64'(rx_full), 64'h1);
      tick();
      pulse_read();
      check("ovr_read_full", 64'(rx_full), 64'h0);
      check("ovr_read_flag", 64'(overrun), 64'h0);

      // Read coinciding with completion while full (and overrun set)
      exp_q.push_back(64'hDEAD_BEEF_CAFE_F00D);
      send_bits(64'hDEAD_BEEF_CAFE_F00D, 64, 1'b0, 1'b0);
      check_pop("sim_first_data");
      tick();
      send_bits(64'h5555_AAAA_3333_CCCC, 64, 1'b0, 1'b0);
      check("sim_pre_overrun", 64'(overrun), 64'h1);
      tick();
      exp_q.push_back(64'h0F0F_1234_8000_0001);
      send_bits(64'h0F0F_1234_8000_0001, 64, 1'b0, 1'b1);
      check_pop("sim_rx_data");
      check("sim_rx_full", 64'(rx_full), 64'h1);
      check("sim_overrun", 64'(overrun), 64'h0);

      // Reset mid-word (holding register still full), then a fresh word
      tick();
      send_bits(64'h89AB_CDEF_FFFF_FFFF, 35, 1'b0, 1'b0);
      tick();
      check("rst_mid_busy_before", 64'(busy), 64'h1);
      rst = 1'b1;
      rising_edge_found = 1'b1;
      data_read = 1'b1;
      tick();
      rst = 1'b0;
      rising_edge_found = 1'b0;
      data_read = 1'b0;
      check("rst_mid_rx_data", rx_data, 64'h0);
      check("rst_mid_rx_full", 64'(rx_full), 64'h0);
      check("rst_mid_overrun", 64'(overrun), 64'h0);
      check("rst_mid_busy", 64'(busy), 64'h0);
      check("rst_mid_byte_received", 64'(byte_received), 64'h0);
      exp_q.push_back(64'hFFFF_0000_FFFF_0000);
      send_bits(64'hFFFF_0000_FFFF_0000, 64, 1'b0, 1'b0);
      check("post_rst_full", 64'(rx_full), 64'h1);
      check_pop("post_rst_data");
      tick();

      check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
